// File: rtl/ball_motion_ctrl.sv
// rtl/ball_motion_ctrl.sv - three-ball pong physics: motion, wall/paddle bounces, speed levels, game over (optional pause: BALL_PAUSE_EN)
module ball_motion_ctrl #(
    parameter int HITS_PER_LEVEL = 4,
    parameter int TOP_MARGIN     = 25,
    parameter int BOTTOM_LIMIT   = 472,
    parameter int LEFT_LIMIT     = 41,
    parameter int RIGHT_LIMIT    = 592
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_tick,
    input  logic       start,
`ifdef BALL_PAUSE_EN
    input  logic       pause,
`endif
    input  logic [9:0] paddle1_y,
    input  logic [9:0] paddle2_y,
    output logic [9:0] ball_x_0,
    output logic [9:0] ball_x_1,
    output logic [9:0] ball_x_2,
    output logic [9:0] ball_y_0,
    output logic [9:0] ball_y_1,
    output logic [9:0] ball_y_2,
    output logic [3:0] ball_speed,
    output logic       game_over,
    output logic [1:0] lost_side
);

    // 11-bit bounds so y+speed / x+speed comparisons never wrap
    localparam logic [10:0] TOP_Y   = 11'(TOP_MARGIN);
    localparam logic [10:0] BOT_Y   = 11'(BOTTOM_LIMIT);
    localparam logic [10:0] LEFT_X  = 11'(LEFT_LIMIT);
    localparam logic [10:0] RIGHT_X = 11'(RIGHT_LIMIT);
    localparam logic [4:0]  LEVEL_HITS = 5'(HITS_PER_LEVEL);

    localparam logic [9:0] SERVE_X = 10'd316;
    localparam logic [9:0] SERVE_Y [3] = '{10'd100, 10'd220, 10'd340};
    localparam logic [2:0] SERVE_DX = 3'b101;   // 1 = moving right
    localparam logic [2:0] SERVE_DY = 3'b011;   // 1 = moving down
    localparam logic [3:0] SERVE_SPEED = 4'd2;
    localparam logic [3:0] MAX_SPEED   = 4'd5;

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t     state;
    logic [9:0] x_q [3];
    logic [9:0] y_q [3];
    logic [2:0] dx_q;
    logic [2:0] dy_q;
    logic [3:0] speed_q;
    logic [3:0] hit_cnt_q;

    logic [9:0] x_n [3];
    logic [9:0] y_n [3];
    logic [2:0] dx_n;
    logic [2:0] dy_n;
    logic [2:0] hit_n;
    logic [2:0] miss_l_n;
    logic [2:0] miss_r_n;
    logic [1:0] nhits;
    logic [4:0] cnt_sum;
    logic       paused;

`ifdef BALL_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    // Ball rows overlap the paddle rows p+25 .. p+97
    function automatic logic overlap(input logic [9:0] y, input logic [9:0] p);
        overlap = (({1'b0, y} + 11'd7) >= ({1'b0, p} + 11'd25)) &&
                  ({1'b0, y} <= ({1'b0, p} + 11'd97));
    endfunction

    // Returns {new_dy, new_y}
    function automatic logic [10:0] move_y(input logic [9:0] y, input logic down,
                                           input logic [3:0] spd);
        logic [10:0] y11;
        logic [10:0] s11;
        logic [9:0]  ny;
        logic        ndy;
        y11 = {1'b0, y};
        s11 = {7'd0, spd};
        ndy = down;
        ny  = down ? (y + {6'd0, spd}) : (y - {6'd0, spd});
        // y - speed <= top rewritten as y <= top + speed to avoid underflow
        if (!down && (y11 <= TOP_Y + s11)) begin
            ny  = TOP_Y[9:0];
            ndy = 1'b1;
        end else if (down && (y11 + s11 >= BOT_Y)) begin
            ny  = BOT_Y[9:0];
            ndy = 1'b0;
        end
        move_y = {ndy, ny};
    endfunction

    // Returns {miss_left, miss_right, hit, new_dx, new_x}
    function automatic logic [13:0] move_x(input logic [9:0] x, input logic right,
                                           input logic [9:0] y, input logic [3:0] spd,
                                           input logic [9:0] pad_l, input logic [9:0] pad_r);
        logic [10:0] x11;
        logic [10:0] s11;
        logic [9:0]  nx;
        logic        ndx;
        logic        hit;
        logic        ml;
        logic        mr;
        x11 = {1'b0, x};
        s11 = {7'd0, spd};
        nx  = right ? (x + {6'd0, spd}) : (x - {6'd0, spd});
        ndx = right;
        hit = 1'b0;
        ml  = 1'b0;
        mr  = 1'b0;
        if (!right && (x11 <= LEFT_X + s11)) begin
            if (overlap(y, pad_l)) begin
                nx  = LEFT_X[9:0];
                ndx = 1'b1;
                hit = 1'b1;
            end else begin
                ml = 1'b1;
            end
        end else if (right && (x11 + s11 >= RIGHT_X)) begin
            if (overlap(y, pad_r)) begin
                nx  = RIGHT_X[9:0];
                ndx = 1'b0;
                hit = 1'b1;
            end else begin
                mr = 1'b1;
            end
        end
        move_x = {ml, mr, hit, ndx, nx};
    endfunction

    // Candidate next positions/directions of all three balls for this tick
    always_comb begin
        dx_n     = dx_q;
        dy_n     = dy_q;
        hit_n    = '0;
        miss_l_n = '0;
        miss_r_n = '0;
        for (int i = 0; i < 3; i++) begin
            x_n[i] = x_q[i];
            y_n[i] = y_q[i];
            {dy_n[i], y_n[i]} = move_y(y_q[i], dy_q[i], speed_q);
            {miss_l_n[i], miss_r_n[i], hit_n[i], dx_n[i], x_n[i]} =
                move_x(x_q[i], dx_q[i], y_q[i], speed_q, paddle1_y, paddle2_y);
        end
        nhits   = {1'b0, hit_n[0]} + {1'b0, hit_n[1]} + {1'b0, hit_n[2]};
        cnt_sum = {1'b0, hit_cnt_q} + {3'd0, nhits};
    end

    // Game FSM with all ball state and outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            for (int i = 0; i < 3; i++) begin
                x_q[i] <= SERVE_X;
                y_q[i] <= SERVE_Y[i];
            end
            dx_q      <= SERVE_DX;
            dy_q      <= SERVE_DY;
            speed_q   <= SERVE_SPEED;
            hit_cnt_q <= '0;
            game_over <= 1'b0;
            lost_side <= 2'b00;
        end else begin
            case (state)
                PLAY: begin
                    if (refresh_tick && !paused) begin
                        if ((|miss_l_n) || (|miss_r_n)) begin
                            // Balls freeze where they were; hits this tick are discarded
                            state     <= OVER;
                            game_over <= 1'b1;
                            lost_side <= {|miss_r_n, |miss_l_n};
                        end else begin
                            for (int i = 0; i < 3; i++) begin
                                x_q[i] <= x_n[i];
                                y_q[i] <= y_n[i];
                            end
                            dx_q <= dx_n;
                            dy_q <= dy_n;
                            if (cnt_sum >= LEVEL_HITS) begin
                                hit_cnt_q <= 4'(cnt_sum - LEVEL_HITS);
                                if (speed_q < MAX_SPEED) begin
                                    speed_q <= speed_q + 4'd1;
                                end
                            end else begin
                                hit_cnt_q <= cnt_sum[3:0];
                            end
                        end
                    end
                end
                default: begin
                    // IDLE and OVER: only start matters, ticks are ignored
                    if (start) begin
                        state     <= PLAY;
                        for (int i = 0; i < 3; i++) begin
                            x_q[i] <= SERVE_X;
                            y_q[i] <= SERVE_Y[i];
                        end
                        dx_q      <= SERVE_DX;
                        dy_q      <= SERVE_DY;
                        speed_q   <= SERVE_SPEED;
                        hit_cnt_q <= '0;
                        game_over <= 1'b0;
                        lost_side <= 2'b00;
                    end
                end
            endcase
        end
    end

    assign ball_x_0   = x_q[0];
    assign ball_x_1   = x_q[1];
    assign ball_x_2   = x_q[2];
    assign ball_y_0   = y_q[0];
    assign ball_y_1   = y_q[1];
    assign ball_y_2   = y_q[2];
    assign ball_speed = speed_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb/tb_ball_motion_ctrl.sv - randomized bench for ball_motion_ctrl against a behavioural pong model
module tb_ball_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       refresh_tick;
    logic       start;
    logic       pause;
    logic [9:0] paddle1_y;
    logic [9:0] paddle2_y;
    logic [9:0] ball_x_0, ball_x_1, ball_x_2;
    logic [9:0] ball_y_0, ball_y_1, ball_y_2;
    logic [3:0] ball_speed;
    logic       game_over;
    logic [1:0] lost_side;

    ball_motion_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .refresh_tick (refresh_tick),
        .start        (start),
`ifdef BALL_PAUSE_EN
        .pause        (pause),
`endif
        .paddle1_y    (paddle1_y),
        .paddle2_y    (paddle2_y),
        .ball_x_0     (ball_x_0),
        .ball_x_1     (ball_x_1),
        .ball_x_2     (ball_x_2),
        .ball_y_0     (ball_y_0),
        .ball_y_1     (ball_y_1),
        .ball_y_2     (ball_y_2),
        .ball_speed   (ball_speed),
        .game_over    (game_over),
        .lost_side    (lost_side)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: positions as integers, directions as +1 / -1
    int m_x [3];
    int m_y [3];
    int m_dx [3];
    int m_dy [3];
    int m_speed;
    int m_hits;
    int m_lost;
    bit m_playing;
    bit m_over;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_serve();
        for (int i = 0; i < 3; i++) m_x[i] = 316;
        m_y[0] = 100; m_y[1] = 220; m_y[2] = 340;
        m_dx[0] = 1;  m_dx[1] = -1; m_dx[2] = 1;
        m_dy[0] = 1;  m_dy[1] = 1;  m_dy[2] = -1;
        m_speed = 2;
        m_hits  = 0;
        m_lost  = 0;
        m_over  = 0;
    endtask

    task automatic model_reset();
        model_serve();
        m_playing = 0;
    endtask

    function automatic bit covers(input int y, input int p);
        return (y + 7 >= p + 25) && (y <= p + 97);
    endfunction

    task automatic model_step(input bit st, input bit tk, input bit ps, input int p1, input int p2);
        int nx [3];
        int ny [3];
        int ndx [3];
        int ndy [3];
        int hits;
        bit ml;
        bit mr;
        if (!m_playing) begin
            if (st) begin
                model_serve();
                m_playing = 1;
            end
            return;
        end
        if (!tk || ps) return;
        hits = 0; ml = 0; mr = 0;
        for (int i = 0; i < 3; i++) begin
            ndy[i] = m_dy[i];
            if (m_dy[i] < 0 && m_y[i] - m_speed <= 25) begin
                ny[i] = 25; ndy[i] = 1;
            end else if (m_dy[i] > 0 && m_y[i] + m_speed >= 472) begin
                ny[i] = 472; ndy[i] = -1;
            end else begin
                ny[i] = m_y[i] + m_dy[i] * m_speed;
            end
            ndx[i] = m_dx[i];
            nx[i]  = m_x[i] + m_dx[i] * m_speed;
            if (m_dx[i] < 0 && m_x[i] - m_speed <= 41) begin
                if (covers(m_y[i], p1)) begin nx[i] = 41; ndx[i] = 1; hits++; end
                else ml = 1;
            end else if (m_dx[i] > 0 && m_x[i] + m_speed >= 592) begin
                if (covers(m_y[i], p2)) begin nx[i] = 592; ndx[i] = -1; hits++; end
                else mr = 1;
            end
        end
        if (ml || mr) begin
            m_playing = 0;
            m_over    = 1;
            m_lost    = (ml ? 1 : 0) + (mr ? 2 : 0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_x[i] = nx[i]; m_y[i] = ny[i]; m_dx[i] = ndx[i]; m_dy[i] = ndy[i];
            end
            m_hits += hits;
            if (m_hits >= 4) begin
                m_hits -= 4;
                if (m_speed < 5) m_speed++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".x0"}, int'(ball_x_0), m_x[0]);
        check({tag, ".x1"}, int'(ball_x_1), m_x[1]);
        check({tag, ".x2"}, int'(ball_x_2), m_x[2]);
        check({tag, ".y0"}, int'(ball_y_0), m_y[0]);
        check({tag, ".y1"}, int'(ball_y_1), m_y[1]);
        check({tag, ".y2"}, int'(ball_y_2), m_y[2]);
        check({tag, ".speed"}, int'(ball_speed), m_speed);
        check({tag, ".game_over"}, int'(game_over), int'(m_over));
        check({tag, ".lost_side"}, int'(lost_side), m_lost);
    endtask

    // One clock: drive at negedge, model at posedge, compare at the next negedge
    task automatic cycle(input bit st, input bit tk, input bit ps, input int p1, input int p2,
                         input string tag);
        start        = st;
        refresh_tick = tk;
        pause        = ps;
        paddle1_y    = 10'(p1);
        paddle2_y    = 10'(p2);
        @(posedge clk);
        model_step(st, tk, ps, p1, p2);
        @(negedge clk);
        check_all(tag);
    endtask

    // Reset asserted between clock edges; outputs must react before any edge
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic int track(input int y);
        return (y > 57) ? y - 57 : 0;
    endfunction

    initial begin
        int p1;
        int p2;
        bit st;
        bit tk;
        bit ps;
        reset = 1'b1; start = 1'b0; refresh_tick = 1'b0; pause = 1'b0;
        paddle1_y = '0; paddle2_y = '0;
        model_reset();
        #1;
        check_all("por");
        @(negedge clk);
        reset = 1'b0;

        // Ticks before any start leave the serve position alone
        for (int t = 0; t < 3; t++) cycle(0, 1, 0, 0, 0, "idle_tick");
        check("idle_x1", int'(ball_x_1), 316);
        check("idle_y2", int'(ball_y_2), 340);

        cycle(1, 0, 0, 0, 0, "start");
        cycle(0, 1, 0, 0, 0, "tick1");
        check("tick1_x0", int'(ball_x_0), 318);
        check("tick1_y0", int'(ball_y_0), 102);
        check("tick1_x1", int'(ball_x_1), 314);
        check("tick1_y2", int'(ball_y_2), 338);
        cycle(1, 0, 0, 0, 0, "start_in_play");

        async_reset("rst_mid_play");
        cycle(0, 1, 0, 0, 0, "idle_after_rst");

        // Scripted game: bottom bounce of ball1, then right miss with hits discarded
        cycle(1, 0, 0, 400, 330, "start2");
        for (int t = 1; t <= 138; t++) begin
            cycle(0, 1, 0, 400, 330, "script");
            if (t == 126) check("y1_at_bottom", int'(ball_y_1), 472);
            if (t == 127) check("y1_after_bounce", int'(ball_y_1), 470);
        end
        check("over_flag", int'(game_over), 1);
        check("over_lost", int'(lost_side), 2);
        check("over_speed", int'(ball_speed), 2);
        check("over_hold_x0", int'(ball_x_0), 590);
        check("over_hold_x1", int'(ball_x_1), 42);
        cycle(0, 1, 0, 400, 330, "over_tick");
        cycle(1, 1, 0, 400, 330, "restart");
        check("restart_x0", int'(ball_x_0), 316);
        check("restart_y1", int'(ball_y_1), 220);
        check("restart_go", int'(game_over), 0);
        cycle(0, 1, 0, 400, 330, "resume");

`ifdef BALL_PAUSE_EN
        for (int t = 0; t < 5; t++) cycle(0, 1, 1, 400, 330, "paused");
        cycle(0, 1, 0, 400, 330, "unpaused");
`endif

        // Randomized play with paddles mostly chasing balls
        for (int n = 0; n < 4000; n++) begin
            st = ($urandom_range(0, 30) == 0);
            tk = ($urandom_range(0, 2) != 0);
            ps = 1'b0;
`ifdef BALL_PAUSE_EN
            ps = ($urandom_range(0, 7) == 0);
`endif
            p1 = ($urandom_range(0, 7) != 0) ? track(m_y[1]) : int'($urandom_range(0, 450));
            case ($urandom_range(0, 2))
                0: p2 = track(m_y[0]);
                1: p2 = track(m_y[2]);
                default: p2 = int'($urandom_range(0, 450));
            endcase
            cycle(st, tk, ps, p1, p2, "rand");
            if ($urandom_range(0, 799) == 0) async_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
